// File: rtl/poly_byte_decode12_pkg.sv
// Shared ML-KEM constants, decoder FSM state encoding and the ByteDecode12 triple unpacker.
package kyber_pkg;

    localparam int KYBER_Q             = 3329;
    localparam int KYBER_N             = 256;
    localparam int KYBER_COEF_BITS     = 12;
    localparam int BYTE_DECODE12_BYTES = 384;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FLUSH,
        ST_DONE
    } dec_state_e;

    typedef struct packed {
        logic [KYBER_COEF_BITS-1:0] c1;
        logic [KYBER_COEF_BITS-1:0] c0;
    } coef_pair_t;

    // Three little-endian bytes carry two 12-bit coefficients; b1 is split by nibble.
    function automatic coef_pair_t unpack12(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
        coef_pair_t p;
        p.c0 = {b1[3:0], b0};
        p.c1 = {b2, b1[7:4]};
        return p;
    endfunction

endpackage

// File: rtl/poly_byte_decode12_if.sv
// Byte-stream input, dual RAM write ports and start/done control of the ByteDecode12 stage.
interface poly_byte_decode12_if #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 16
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we_1;
    logic [ADDR_W-1:0] addr_1;
    logic [WIDTH-1:0]  din_1;
    logic              we_2;
    logic [ADDR_W-1:0] addr_2;
    logic [WIDTH-1:0]  din_2;
    logic              busy;
    logic              done;
    logic              mod_err;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, we_1, addr_1, din_1, we_2, addr_2, din_2, busy, done, mod_err
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, we_1, addr_1, din_1, we_2, addr_2, din_2, busy, done, mod_err
    );
endinterface

// File: rtl/poly_byte_decode12.sv
// ByteDecode12: 384-byte stream -> 256 coefficients, two RAM writes per byte triple (range check: POLY_BYTE_DECODE12_MODCHECK_EN).
// Latency: write pulse 1 cycle after each third byte; done 2 cycles after the last byte.
// Backpressure: in_ready is high only in COLLECT; in_valid low simply stalls, no bubbles otherwise.
module poly_byte_decode12
    import kyber_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 16,
    parameter int Q      = KYBER_Q
) (
    input  logic                 clk,
    input  logic                 rst,
    poly_byte_decode12_if.master bus
);

    localparam int PAIR_W = ADDR_W - 1;

    dec_state_e        state_q,    state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [PAIR_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [7:0]        b0_q,       b0_d;
    logic [7:0]        b1_q,       b1_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr1_q,    addr1_d;
    logic [ADDR_W-1:0] addr2_q,    addr2_d;
    logic [WIDTH-1:0]  din1_q,     din1_d;
    logic [WIDTH-1:0]  din2_q,     din2_d;
    coef_pair_t        pair;

    // The third byte is taken straight from the bus so the pair commits on its transfer edge.
    assign pair = unpack12(b0_q, b1_q, bus.in_data);

`ifdef POLY_BYTE_DECODE12_MODCHECK_EN
    logic range_err;
    logic mod_err_q, mod_err_d;

    assign range_err   = (int'(pair.c0) >= Q) || (int'(pair.c1) >= Q);
    assign bus.mod_err = mod_err_q;
`else
    // Q only feeds the range check, which is not built here.
    if (Q != KYBER_Q) begin : g_custom_q
    end
    assign bus.mod_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pair_cnt_d = pair_cnt_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        we_d       = 1'b0;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        din1_d     = din1_q;
        din2_d     = din2_q;
`ifdef POLY_BYTE_DECODE12_MODCHECK_EN
        mod_err_d  = mod_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_COLLECT;
                    byte_cnt_d = 2'd0;
                    pair_cnt_d = '0;
`ifdef POLY_BYTE_DECODE12_MODCHECK_EN
                    mod_err_d  = 1'b0;
`endif
                end
            end
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    case (byte_cnt_q)
                        2'd0: begin
                            b0_d       = bus.in_data;
                            byte_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            b1_d       = bus.in_data;
                            byte_cnt_d = 2'd2;
                        end
                        default: begin
                            byte_cnt_d = 2'd0;
                            we_d       = 1'b1;
                            addr1_d    = {pair_cnt_q, 1'b0};
                            addr2_d    = {pair_cnt_q, 1'b1};
                            din1_d     = WIDTH'(pair.c0);
                            din2_d     = WIDTH'(pair.c1);
                            pair_cnt_d = pair_cnt_q + 1'b1;
`ifdef POLY_BYTE_DECODE12_MODCHECK_EN
                            mod_err_d  = mod_err_q | range_err;
`endif
                            if (pair_cnt_q == '1) begin
                                state_d = ST_FLUSH;
                            end
                        end
                    endcase
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            pair_cnt_q <= '0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            we_q       <= 1'b0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            din1_q     <= '0;
            din2_q     <= '0;
`ifdef POLY_BYTE_DECODE12_MODCHECK_EN
            mod_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pair_cnt_q <= pair_cnt_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            we_q       <= we_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            din1_q     <= din1_d;
            din2_q     <= din2_d;
`ifdef POLY_BYTE_DECODE12_MODCHECK_EN
            mod_err_q  <= mod_err_d;
`endif
        end
    end

    assign bus.in_ready = (state_q == ST_COLLECT);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.we_1     = we_q;
    assign bus.we_2     = we_q;
    assign bus.addr_1   = addr1_q;
    assign bus.addr_2   = addr2_q;
    assign bus.din_1    = din1_q;
    assign bus.din_2    = din2_q;

endmodule

// File: tb/tb_poly_byte_decode12.sv
// Scoreboard bench for poly_byte_decode12: stimulus queues expected RAM writes, a negedge monitor checks them.
module tb_poly_byte_decode12;
    import kyber_pkg::*;

    localparam int ADDR_W = 8;
    localparam int WIDTH  = 16;
    localparam int NPAIR  = KYBER_N / 2;
`ifdef POLY_BYTE_DECODE12_MODCHECK_EN
    localparam bit MODCHK = 1'b1;
`else
    localparam bit MODCHK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  a1;
        logic [15:0] d1;
        logic [7:0]  a2;
        logic [15:0] d2;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_byte_decode12_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus();

    poly_byte_decode12 #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .Q(KYBER_Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t         exp_q[$];
    logic [15:0] ram  [KYBER_N];
    logic [15:0] gold [KYBER_N];
    logic [7:0]  stream [BYTE_DECODE12_BYTES];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          last_xfer = -100;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [7:0]  last_a1 = 8'h00;
    logic [7:0]  last_a2 = 8'h00;
    logic        exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin : monitor
        wr_t w;
        ncyc++;
        if (!rst) begin
            if (bus.we_1 || bus.we_2) begin
                chk("we_pair", {30'd0, bus.we_1, bus.we_2}, 32'd3);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr_1=0x%0h din_1=0x%0h, expected no write", bus.addr_1, bus.din_1);
                end else begin
                    w = exp_q.pop_front();
                    chk("addr_1", 32'(bus.addr_1), 32'(w.a1));
                    chk("din_1",  32'(bus.din_1),  32'(w.d1));
                    chk("addr_2", 32'(bus.addr_2), 32'(w.a2));
                    chk("din_2",  32'(bus.din_2),  32'(w.d2));
                    if (MODCHK && (int'(w.d1) >= KYBER_Q || int'(w.d2) >= KYBER_Q)) exp_err = 1'b1;
                end
                chk("mod_err_at_write", 32'(bus.mod_err), 32'(exp_err));
                ram[bus.addr_1] = bus.din_1;
                ram[bus.addr_2] = bus.din_2;
                last_a1 = bus.addr_1;
                last_a2 = bus.addr_2;
                wr_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_latency", 32'(ncyc - last_xfer), 32'd2);
                chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
            if (bus.in_valid && bus.in_ready) last_xfer = ncyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            bus.in_valid = 1'b0;
            tick();
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=0 after 50 cycles, expected 1");
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
    endtask

    // Expected pair built from nibble concatenation of the three stream bytes.
    task automatic push_pair(input int p);
        wr_t        w;
        logic [7:0] x0, x1, x2;
        logic [6:0] pi;
        x0 = stream[3*p];
        x1 = stream[3*p+1];
        x2 = stream[3*p+2];
        pi = p[6:0];
        w.a1 = {pi, 1'b0};
        w.a2 = {pi, 1'b1};
        w.d1 = {4'h0, x1[3:0], x0};
        w.d2 = {4'h0, x2, x1[7:4]};
        gold[2*p]   = w.d1;
        gold[2*p+1] = w.d2;
        exp_q.push_back(w);
    endtask

    task automatic feed(input int from, input int to, input int gap_pct, input bit stray);
        for (int i = from; i < to; i++) begin
            if (i % 3 == 2) push_pair(i / 3);
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            if (stray && (i % 50 == 7)) bus.start = 1'b1;
            send(stream[i]);
            bus.start = 1'b0;
        end
    endtask

    task automatic begin_decode(output int d0);
        for (int i = 0; i < KYBER_N; i++) ram[i] = 16'hDEAD;
        exp_err = 1'b0;
        wr_cnt  = 0;
        d0      = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("in_ready_after_start", 32'(bus.in_ready), 32'd1);
        chk("mod_err_cleared_by_start", 32'(bus.mod_err), 32'd0);
    endtask

    task automatic finish_decode(input int d0, input bit stray);
        int t = 0;
        bus.in_valid = 1'b0;
        if (stray) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        while (done_cnt == d0 && t < 20) begin
            tick();
            t++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done pulse within 20 cycles");
        end
        repeat (3) tick();
        chk("done_count", 32'(done_cnt), 32'(d0 + 1));
        chk("idle_after_done", 32'(bus.busy), 32'd0);
        chk("write_count", 32'(wr_cnt), 32'(NPAIR));
        chk("last_addr_1", 32'(last_a1), 32'hFE);
        chk("last_addr_2", 32'(last_a2), 32'hFF);
        for (int i = 0; i < KYBER_N; i++) chk("ram_word", 32'(ram[i]), 32'(gold[i]));
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int d0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we_1",     32'(bus.we_1),     32'd0);
        chk("rst_addr_2",   32'(bus.addr_2),   32'd0);
        chk("rst_din_1",    32'(bus.din_1),    32'd0);
        chk("rst_mod_err",  32'(bus.mod_err),  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_no_ready", 32'(bus.in_ready), 32'd0);

        // Decode 1: directed triples, including the 3328/3329 range boundary.
        for (int i = 0; i < BYTE_DECODE12_BYTES; i++) stream[i] = 8'((i * 7 + 3) & 8'h7F);
        stream[0] = 8'h01; stream[1] = 8'h23; stream[2] = 8'h45;
        stream[3] = 8'h00; stream[4] = 8'h0D; stream[5] = 8'h00;
        stream[6] = 8'h01; stream[7] = 8'h0D; stream[8] = 8'h00;
        begin_decode(d0);
        feed(0, 3, 0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("mod_err_first_triple", 32'(bus.mod_err), 32'd0);
        feed(3, 6, 0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("mod_err_3328", 32'(bus.mod_err), 32'd0);
        feed(6, 9, 0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("mod_err_3329", 32'(bus.mod_err), 32'(MODCHK));
        feed(9, BYTE_DECODE12_BYTES, 0, 1'b0);
        finish_decode(d0, 1'b0);
        chk("mod_err_sticky", 32'(bus.mod_err), 32'(MODCHK));

        // Decode 2: random bytes, continuous stream.
        for (int i = 0; i < BYTE_DECODE12_BYTES; i++) stream[i] = 8'($urandom_range(0, 255));
        begin_decode(d0);
        feed(0, BYTE_DECODE12_BYTES, 0, 1'b0);
        finish_decode(d0, 1'b0);

        // Decode 3: same bytes, random gaps and start pulses while busy.
        begin_decode(d0);
        feed(0, BYTE_DECODE12_BYTES, 30, 1'b1);
        finish_decode(d0, 1'b1);

        // Reset on the edge that would commit pair 32: that write must never appear.
        begin_decode(d0);
        feed(0, 98, 0, 1'b0);
        bus.in_data  = stream[98];
        bus.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("midrst_busy",     32'(bus.busy),     32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_we_1",     32'(bus.we_1),     32'd0);
        chk("midrst_we_2",     32'(bus.we_2),     32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_pending_writes", 32'(exp_q.size()), 32'd0);
        chk("midrst_write_count", 32'(wr_cnt), 32'd32);

        // Decode 4: fresh decode after reset starts again at address 0.
        for (int i = 0; i < BYTE_DECODE12_BYTES; i++) stream[i] = 8'($urandom_range(0, 255));
        begin_decode(d0);
        feed(0, 3, 0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("restart_first_addr", 32'(last_a1), 32'h00);
        feed(3, BYTE_DECODE12_BYTES, 0, 1'b0);
        finish_decode(d0, 1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("total_done", 32'(done_cnt), 32'd4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
